// File: rtl/spi_note_pkg.sv
// spi_note_pkg: shared constants, FSM state type and frame packing for the SPI note master.
// Optional feature macro: SPI_NOTE_CHECKSUM_EN. When defined, the top byte of the frame carries
// note1 ^ note2 ^ note3. Otherwise it is 8'h00.
package spi_note_pkg;

  localparam int unsigned FRAME_BITS = 32;
  localparam int unsigned NOTE_W     = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StGap
  } spi_state_t;

  // Frame layout, MSB first on the wire: {pad, note3, note2, note1}.
  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [NOTE_W-1:0] note1,
                                                        input logic [NOTE_W-1:0] note2,
                                                        input logic [NOTE_W-1:0] note3);
    logic [NOTE_W-1:0] pad;
`ifdef SPI_NOTE_CHECKSUM_EN
    pad = note1 ^ note2 ^ note3;
`else
    pad = '0;
`endif
    return {pad, note3, note2, note1};
  endfunction

endpackage

// File: rtl/spi_note_master_if.sv
// spi_note_master_if: note-triple handshake plus SPI pins of the note master.
//   in_valid / note1..note3 : producer -> master (triple offered)
//   in_ready                : master -> producer (triple may be accepted)
//   sck / sdo               : SPI clock (idles low) and MSB-first data
//   busy / frame_done       : status (frame in flight / last falling sck edge pulse)
// Modport master is the SPI master block, modport slave is the producer/observer side.
interface spi_note_master_if;

  logic                              in_valid;
  logic                              in_ready;
  logic [spi_note_pkg::NOTE_W-1:0]   note1;
  logic [spi_note_pkg::NOTE_W-1:0]   note2;
  logic [spi_note_pkg::NOTE_W-1:0]   note3;
  logic                              sck;
  logic                              sdo;
  logic                              busy;
  logic                              frame_done;

  modport master (
    input  in_valid, note1, note2, note3,
    output in_ready, sck, sdo, busy, frame_done
  );

  modport slave (
    output in_valid, note1, note2, note3,
    input  in_ready, sck, sdo, busy, frame_done
  );

endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: sck phase divider for the SPI note master.
//   clk, reset_n : system clock, asynchronous active-low reset
//   en           : count while high
//   clr          : hold the counter at zero
//   phase_end    : high in the last cycle (count CLK_DIV-1) of each enabled phase
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic phase_end
);

  localparam int unsigned     DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] cnt_q, cnt_d;

  assign phase_end = en && (cnt_q == DivLast);

  // Self-clearing at phase_end so every phase starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || phase_end) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_note_master.sv
// spi_note_master: accepts one note triple per frame and shifts it out as a 32-bit SPI frame
// (mode 0: sck idles low, slave samples on rising sck, data changes on falling sck).
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus          : spi_note_master_if.master (handshake, notes, sck/sdo, busy, frame_done)
// Parameters: CLK_DIV (sck half-period in clk cycles, >= 1), GAP_CYCLES (idle cycles after
// each frame before in_ready returns, >= 0).
// Optional feature macro: SPI_NOTE_CHECKSUM_EN (pad byte = note1 ^ note2 ^ note3).
// All outputs are registered.
module spi_note_master
  import spi_note_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  spi_note_master_if.master  bus
);

  localparam int unsigned     GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
  localparam logic [4:0]      LastBit = 5'(FRAME_BITS - 1);

  spi_state_t            state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [4:0]            bit_cnt_q;
  logic [GapW-1:0]       gap_cnt_q;
  logic                  in_ready_q;
  logic                  sck_q;
  logic                  sdo_q;
  logic                  busy_q;
  logic                  frame_done_q;

  logic                  div_en;
  logic                  phase_end;

  assign div_en = (state_q == StShiftLo) || (state_q == StShiftHi);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (div_en),
    .clr       (!div_en),
    .phase_end (phase_end)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      in_ready_q   <= 1'b0;
      sck_q        <= 1'b0;
      sdo_q        <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sck_q <= 1'b0;
          sdo_q <= 1'b0;
          // in_ready_q is registered, so the release edge itself never accepts.
          if (bus.in_valid && in_ready_q) begin
            shift_q    <= pack_frame(bus.note1, bus.note2, bus.note3);
            bit_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StShiftLo;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        StShiftLo: begin
          sdo_q <= shift_q[FRAME_BITS-1];
          if (phase_end) begin
            sck_q   <= 1'b1;
            state_q <= StShiftHi;
          end
        end
        StShiftHi: begin
          if (phase_end) begin
            sck_q <= 1'b0;
            if (bit_cnt_q == LastBit) begin
              frame_done_q <= 1'b1;
              sdo_q        <= 1'b0;
              if (GAP_CYCLES == 0) begin
                busy_q     <= 1'b0;
                in_ready_q <= 1'b1;
                state_q    <= StIdle;
              end else begin
                gap_cnt_q <= '0;
                state_q   <= StGap;
              end
            end else begin
              // Next bit goes out on the falling edge itself, not a cycle later.
              shift_q   <= shift_q << 1;
              sdo_q     <= shift_q[FRAME_BITS-2];
              bit_cnt_q <= bit_cnt_q + 1'b1;
              state_q   <= StShiftLo;
            end
          end
        end
        StGap: begin
          sck_q <= 1'b0;
          sdo_q <= 1'b0;
          if (gap_cnt_q == GapLast) begin
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.sck        = sck_q;
  assign bus.sdo        = sdo_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_note_master.sv
// tb_spi_note_master: two masters (CLK_DIV=4/GAP=2 and CLK_DIV=1/GAP=0) checked every cycle
// against a timing model derived from accept-edge offsets, plus a receive-only slave model fed
// from sck/sdo, plus literal expectations for frame contents and latencies.
module tb_spi_note_master;

  localparam int unsigned DivA = 4;
  localparam int unsigned GapA = 2;
  localparam int unsigned DivB = 1;
  localparam int unsigned GapB = 0;

`ifdef SPI_NOTE_CHECKSUM_EN
  localparam logic [31:0] FirstFrame  = 32'h70563412;
  localparam logic [31:0] ChangedFrame = 32'hDDCCBBAA;
`else
  localparam logic [31:0] FirstFrame  = 32'h00563412;
  localparam logic [31:0] ChangedFrame = 32'h00CCBBAA;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_note_master_if bus_a ();
  spi_note_master_if bus_b ();

  spi_note_master #(.CLK_DIV(DivA), .GAP_CYCLES(GapA)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  spi_note_master #(.CLK_DIV(DivB), .GAP_CYCLES(GapB)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int rel = 0;

  // Model state per instance
  bit          have[2]     = '{0, 0};
  int          e0[2]       = '{0, 0};
  logic [31:0] frm[2]      = '{32'h0, 32'h0};
  logic [31:0] expq_a[$];
  logic [31:0] expq_b[$];
  // Slave loopback model per instance
  logic        prev_sck[2] = '{1'b0, 1'b0};
  int          sbits[2]    = '{0, 0};
  logic [31:0] sshift[2]   = '{32'h0, 32'h0};
  logic [7:0]  sn1[2]      = '{8'h0, 8'h0};
  logic [7:0]  sn2[2]      = '{8'h0, 8'h0};
  logic [7:0]  sn3[2]      = '{8'h0, 8'h0};
  int          rise_cnt[2] = '{0, 0};
  logic [31:0] sf_a[$];
  logic [31:0] sf_b[$];
  // DUT-observed events
  int          acc_a[$];
  int          acc_b[$];
  int          fd_a = 0;
  int          fd_b = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_n) rel <= 0;
    else          rel <= rel + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_frame(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c);
    logic [7:0] pad;
    pad = 8'h00;
`ifdef SPI_NOTE_CHECKSUM_EN
    pad = a ^ b ^ c;
`endif
    return {pad, c, b, a};
  endfunction

  task automatic model_step(input int i, input int d, input int g, input logic v,
                            input logic [7:0] n1, input logic [7:0] n2, input logic [7:0] n3,
                            input logic rdy, input logic sck, input logic sdo,
                            input logic busy, input logic fd);
    logic e_rdy, e_sck, e_sdo, e_busy, e_fd, have_e;
    logic [31:0] ef;
    int o;
    bit act;
    string p;
    p = (i == 0) ? "a" : "b";
    e_rdy = 0; e_sck = 0; e_sdo = 0; e_busy = 0; e_fd = 0; act = 0; o = 0;
    have_e = 0; ef = '0;
    if (!reset_n) begin
      have[i] = 0;
      if (i == 0) expq_a.delete(); else expq_b.delete();
    end else begin
      if (have[i]) begin
        o    = cyc - e0[i];
        act  = (o < 64 * d + g);
        e_fd = (o == 64 * d);
      end
      if (act) begin
        e_busy = 1'b1;
        e_sck  = (o < 64 * d) && (((o / d) % 2) == 1);
        e_sdo  = (o >= 1 && o < 64 * d) ? frm[i][31 - o / (2 * d)] : 1'b0;
      end else begin
        e_rdy = (rel >= 1);
      end
    end
    chk({p, "_in_ready"}, 32'(rdy), 32'(e_rdy));
    chk({p, "_sck"}, 32'(sck), 32'(e_sck));
    chk({p, "_sdo"}, 32'(sdo), 32'(e_sdo));
    chk({p, "_busy"}, 32'(busy), 32'(e_busy));
    chk({p, "_frame_done"}, 32'(fd), 32'(e_fd));
    if (reset_n && !act && e_rdy && v) begin
      have[i] = 1;
      e0[i]   = cyc + 1;
      frm[i]  = ref_frame(n1, n2, n3);
      if (i == 0) expq_a.push_back(frm[i]); else expq_b.push_back(frm[i]);
    end
    if (!reset_n) begin
      sbits[i]    = 0;
      prev_sck[i] = 1'b0;
    end else begin
      if (sck && !prev_sck[i]) begin
        sshift[i] = {sshift[i][30:0], sdo};
        sbits[i]++;
        rise_cnt[i]++;
        if (sbits[i] == 32) begin
          sbits[i] = 0;
          sn1[i] = sshift[i][7:0];
          sn2[i] = sshift[i][15:8];
          sn3[i] = sshift[i][23:16];
          if (i == 0) begin
            sf_a.push_back(sshift[i]);
            if (expq_a.size() > 0) begin ef = expq_a.pop_front(); have_e = 1; end
          end else begin
            sf_b.push_back(sshift[i]);
            if (expq_b.size() > 0) begin ef = expq_b.pop_front(); have_e = 1; end
          end
          if (have_e) chk({p, "_slave_frame"}, sshift[i], ef);
          else        chk({p, "_unexpected_frame"}, 32'd1, 32'd0);
        end
      end
      prev_sck[i] = sck;
    end
  endtask

  always @(negedge clk) begin
    model_step(0, DivA, GapA, bus_a.in_valid, bus_a.note1, bus_a.note2, bus_a.note3,
               bus_a.in_ready, bus_a.sck, bus_a.sdo, bus_a.busy, bus_a.frame_done);
    model_step(1, DivB, GapB, bus_b.in_valid, bus_b.note1, bus_b.note2, bus_b.note3,
               bus_b.in_ready, bus_b.sck, bus_b.sdo, bus_b.busy, bus_b.frame_done);
    if (reset_n && bus_a.in_valid && bus_a.in_ready) acc_a.push_back(cyc + 1);
    if (reset_n && bus_b.in_valid && bus_b.in_ready) acc_b.push_back(cyc + 1);
    if (bus_a.frame_done) fd_a = cyc;
    if (bus_b.frame_done) fd_b = cyc;
  end

  // Offers a triple and returns #2 after the accept edge with in_valid dropped.
  task automatic send(input int i, input logic [7:0] n1, input logic [7:0] n2,
                      input logic [7:0] n3);
    int n;
    logic r;
    if (i == 0) begin
      bus_a.note1 = n1; bus_a.note2 = n2; bus_a.note3 = n3; bus_a.in_valid = 1'b1;
    end else begin
      bus_b.note1 = n1; bus_b.note2 = n2; bus_b.note3 = n3; bus_b.in_valid = 1'b1;
    end
    n = 0;
    r = 1'b0;
    do begin
      @(negedge clk);
      r = (i == 0) ? bus_a.in_ready : bus_b.in_ready;
      n++;
    end while (!r && n < 2000);
    if (!r) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #2;
    if (i == 0) bus_a.in_valid = 1'b0; else bus_b.in_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel_cyc;
    int base;
    int sbase;
    int n;
    bus_a.in_valid = 1'b0; bus_a.note1 = '0; bus_a.note2 = '0; bus_a.note3 = '0;
    bus_b.in_valid = 1'b0; bus_b.note1 = '0; bus_b.note2 = '0; bus_b.note3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus_a.in_ready), 32'd0);
    chk("reset_busy", 32'(bus_a.busy), 32'd0);
    #1;

    // Basic frame; in_valid already high at release must not be taken on the release edge.
    reset_n = 1'b1;
    rel_cyc = cyc;
    send(0, 8'h12, 8'h34, 8'h56);
    repeat (270) @(posedge clk);
    #2;
    if (acc_a.size() > 0) begin
      chk("a_first_accept_delay", 32'(acc_a[0] - rel_cyc), 32'd2);
      chk("a_frame_done_latency", 32'(fd_a - acc_a[0]), 32'd256);
    end else chk("a_no_accept", 32'd0, 32'd1);
    if (sf_a.size() > 0) chk("a_frame0_literal", sf_a[0], FirstFrame);
    else                 chk("a_no_frame", 32'd0, 32'd1);
    chk("a_slave_note1", 32'(sn1[0]), 32'h12);
    chk("a_slave_note2", 32'(sn2[0]), 32'h34);
    chk("a_slave_note3", 32'(sn3[0]), 32'h56);

    // Held in_valid: back-to-back frames, notes changed mid-frame.
    base  = acc_a.size();
    sbase = sf_a.size();
    bus_a.note1 = 8'h01; bus_a.note2 = 8'h02; bus_a.note3 = 8'h03; bus_a.in_valid = 1'b1;
    repeat (100) @(posedge clk);
    #2;
    bus_a.note1 = 8'hAA; bus_a.note2 = 8'hBB; bus_a.note3 = 8'hCC;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (acc_a.size() < base + 3 && n < 1500);
    @(posedge clk);
    #2;
    bus_a.in_valid = 1'b0;
    repeat (270) @(posedge clk);
    #2;
    if (acc_a.size() >= base + 3) begin
      chk("a_accept_spacing_1", 32'(acc_a[base + 1] - acc_a[base]), 32'd259);
      chk("a_accept_spacing_2", 32'(acc_a[base + 2] - acc_a[base + 1]), 32'd259);
    end else chk("a_held_accept_count", 32'(acc_a.size() - base), 32'd3);
    if (sf_a.size() >= sbase + 2) begin
      chk("a_held_frame0", sf_a[sbase], 32'h00030201);
      chk("a_held_frame1", sf_a[sbase + 1], ChangedFrame);
    end else chk("a_held_frame_count", 32'(sf_a.size() - sbase), 32'd3);

    // Reset in the middle of bit 10, while sck and sdo are both high.
    send(0, 8'h00, 8'h00, 8'hFF);
    repeat (84) @(posedge clk);
    #2;
    chk("a_pre_reset_sck", 32'(bus_a.sck), 32'd1);
    chk("a_pre_reset_sdo", 32'(bus_a.sdo), 32'd1);
    chk("a_pre_reset_busy", 32'(bus_a.busy), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("a_rst_sck", 32'(bus_a.sck), 32'd0);
    chk("a_rst_sdo", 32'(bus_a.sdo), 32'd0);
    chk("a_rst_busy", 32'(bus_a.busy), 32'd0);
    chk("a_rst_in_ready", 32'(bus_a.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("a_in_ready_after_release", 32'(bus_a.in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #2;

    // Fast instance: CLK_DIV=1, GAP_CYCLES=0.
    send(1, 8'h12, 8'h34, 8'h56);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_b.frame_done && n < 200);
    chk("b_frame_done_seen", 32'(bus_b.frame_done), 32'd1);
    @(negedge clk);
    chk("b_in_ready_after_fd", 32'(bus_b.in_ready), 32'd1);
    #1;
    chk("b_rising_edges", 32'(rise_cnt[1]), 32'd32);
    if (acc_b.size() > 0) chk("b_frame_done_latency", 32'(fd_b - acc_b[0]), 32'd64);
    else                  chk("b_no_accept", 32'd0, 32'd1);
    if (sf_b.size() > 0) chk("b_frame0_literal", sf_b[0], FirstFrame);
    else                 chk("b_no_frame", 32'd0, 32'd1);
    chk("b_slave_note1", 32'(sn1[1]), 32'h12);
    chk("b_slave_note2", 32'(sn2[1]), 32'h34);
    chk("b_slave_note3", 32'(sn3[1]), 32'h56);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/spi_note_master.md
# spi_note_master

SPI master that serialises three 8-bit note samples into one 32-bit frame and drives them onto `sck`/`sdo` for the keyboard's receive-only SPI slave. It sits on the sample-producing side of the link, e.g. a note sequencer or test FPGA. Its frame format and clock phase match the slave exactly: the slave shifts on rising `sck` and latches the notes after every 32nd bit. It accepts one note triple per frame through a valid/ready handshake.

## Interface
- `CLK_DIV`, 4: `sck` half-period in `clk` cycles; legal range ≥ 1.
- `GAP_CYCLES`, 2: idle `clk` cycles after each frame before `in_ready` returns; legal range ≥ 0.
- `clk` input 1: system clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the note triple on `note1..note3` is valid.
- `in_ready` output 1: the block can accept a triple; reset value 0.
- `note1` input 8: packed into frame bits [7:0].
- `note2` input 8: packed into frame bits [15:8].
- `note3` input 8: packed into frame bits [23:16].
- `sck` output 1: SPI clock; idles low; reset value 0.
- `sdo` output 1: serial data, MSB first; reset value 0.
- `busy` output 1: high from accept until `GAP` ends; reset value 0.
- `frame_done` output 1: one-cycle pulse when the 32nd falling edge of `sck` occurs; reset value 0.

## Operation
- States are `IDLE`, `SHIFT_LO`, `SHIFT_HI` and `GAP`.
- `IDLE`:
  - `in_ready`=1, `sck`=0, `sdo`=0.
  - On `in_valid && in_ready`, load shift register = {pad, note3, note2, note1}, clear the bit counter, and go to `SHIFT_LO`.
  - Pad is 8'h00 (see Configuration).
- `SHIFT_LO`:
  - `sck`=0 and `sdo`=shift[31].
  - After `CLK_DIV` cycles, go to `SHIFT_HI`.
- `SHIFT_HI`:
  - `sck`=1.
  - After `CLK_DIV` cycles, drive `sck` low.
  - If bit counter = 31: pulse `frame_done`; go to `GAP`, or to `IDLE` if `GAP_CYCLES`=0.
  - Otherwise: shift the register left by 1, increment the bit counter, and go to `SHIFT_LO`.
- `GAP`:
  - `sck`=0, `sdo`=0.
  - After `GAP_CYCLES` cycles, go to `IDLE`.
- `in_ready` is high only in `IDLE`. Inputs are ignored in every other state, and a held `in_valid` is not queued.
- Notes are captured only at accept. Input changes during a frame have no effect.
- The bit counter is 5 bits and counts 0..31. It never wraps mid-frame; it is cleared on load.
- The divider counter counts 0..`CLK_DIV`-1 and is cleared on every phase change.
- If `reset_n` is asserted mid-frame, all outputs take their reset values immediately and the state goes to `IDLE`. The slave has no reset and may end up bit-misaligned; realignment is a system-level concern outside this block.
- `in_valid` asserted in the same cycle reset deasserts is not accepted. `in_ready` first rises on the first clock edge after deassertion.

## Timing
- E0 is the accept edge.
- Rising edge k (k=1..32) of `sck` occurs at E0+(2k−1)·`CLK_DIV`.
- Falling edge k occurs at E0+2k·`CLK_DIV`.
- `sdo` changes only at E0+1 and on falling `sck` edges, so it is stable for `CLK_DIV` cycles either side of each rising edge.
- `frame_done` is high for the single cycle that starts at the last falling edge, E0+64·`CLK_DIV`.
- `in_ready` rises `GAP_CYCLES` cycles after `frame_done`.
- Minimum accept-to-accept spacing is 64·`CLK_DIV`+`GAP_CYCLES`+1 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `SPI_NOTE_CHECKSUM_EN` defined: pad byte [31:24] = note1 ^ note2 ^ note3.
- `SPI_NOTE_CHECKSUM_EN` undefined: pad byte = 8'h00.
- Frame length and timing are identical in both cases. The slave ignores [31:24] either way.

## Structure
- Package `spi_note_pkg` holds:
  - `FRAME_BITS`=32 and `NOTE_W`=8;
  - the state enum `spi_state_t`;
  - the function `pack_frame(note1, note2, note3)`, which contains the `SPI_NOTE_CHECKSUM_EN` selection.
- Sub-module `spi_clk_gen` holds the divider counter. Its outputs are `phase_end`, a pulse every `CLK_DIV` cycles while enabled, and its enable/clear inputs are driven from the FSM.

## Test plan
- Reset, then send notes 0x12/0x34/0x56 with `CLK_DIV`=4 and the macro off. Sampling `sdo` at each rising `sck` gives 0x00563412 MSB first. `frame_done` fires at E0+256.
- Same stimulus with `SPI_NOTE_CHECKSUM_EN` defined: the captured frame is 0x70563412.
- Hold `in_valid` high continuously with `GAP_CYCLES`=2. Accepts occur exactly 259 cycles apart, and note changes mid-frame do not alter the frame in flight.
- Assert `reset_n`=0 at bit 10. `sck`, `sdo`, `busy` and `in_ready` go to 0 immediately, and `in_ready`=1 on the first edge after release.
- `CLK_DIV`=1 with `GAP_CYCLES`=0: `sck` toggles every cycle, there are 32 rising edges, and `in_ready` is high the cycle after `frame_done`.
- Loop back into a `spi_slave_receive_only` + `process_spi` model. Its note1/note2/note3 equal 0x12/0x34/0x56 after the frame.
